// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider FSM encoding, latency,
// result field layout and two's-complement helpers.
package mdu_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_CALC = 2'd1;
    localparam div_state_t DIV_FIX  = 2'd2;
    localparam div_state_t DIV_DONE = 2'd3;

    // Accept edge to result-valid cycle, in clocks.
    localparam int unsigned DIV_LATENCY = 34;

    // Result layout {quotient, remainder}; the HI/LO unit swaps these fields.
    localparam int unsigned DIV_WIDTH    = 32;
    localparam int unsigned DIV_QUOT_MSB = 2 * DIV_WIDTH - 1;
    localparam int unsigned DIV_QUOT_LSB = DIV_WIDTH;
    localparam int unsigned DIV_REM_MSB  = DIV_WIDTH - 1;
    localparam int unsigned DIV_REM_LSB  = 0;

    // Helpers work on a 64-bit container; callers zero-extend and truncate to their width.
    function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [63:0] magnitude(input logic [63:0] v, input logic is_neg);
        return cond_neg(v, is_neg);
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative radix-2 restoring divider, signed or unsigned, fixed 34-cycle latency.
// Result {quotient, remainder} is held until the next completed divide.
module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_signed,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 flush,
    output logic                 busy,
    output logic                 m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_t           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 a_neg_q, a_neg_d;
    logic                 b_neg_q, b_neg_d;
    logic                 b_zero_q, b_zero_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic [WIDTH-1:0]     bmag_q, bmag_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [2*WIDTH-1:0]   dout_q, dout_d;
    logic                 valid_q, valid_d;

    logic                 accept;
    logic                 a_sign, b_sign;
    logic [WIDTH:0]       shifted;
    logic                 trial_ok;
    logic [WIDTH-1:0]     q_fix, r_fix;

    assign s_axis_tready      = (state_q == DIV_IDLE);
    assign busy               = (state_q != DIV_IDLE);
    assign m_axis_dout_tvalid = valid_q;
    assign m_axis_dout_tdata  = dout_q;

    assign accept = s_axis_tvalid & s_axis_tready & ~flush;
    assign a_sign = s_axis_signed & s_axis_dividend_tdata[WIDTH-1];
    assign b_sign = s_axis_signed & s_axis_divisor_tdata[WIDTH-1];

    // The restored remainder is always below |B|, so WIDTH bits hold it between steps.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial_ok = (shifted >= {1'b0, bmag_q});

    assign q_fix = WIDTH'(cond_neg(64'(quo_q), a_neg_q ^ b_neg_q));
    assign r_fix = WIDTH'(cond_neg(64'(rem_q), a_neg_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        a_raw_d  = a_raw_q;
        bmag_d   = bmag_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    state_d  = DIV_CALC;
                    cnt_d    = '0;
                    a_neg_d  = a_sign;
                    b_neg_d  = b_sign;
                    b_zero_d = (s_axis_divisor_tdata == '0);
                    a_raw_d  = s_axis_dividend_tdata;
                    bmag_d   = WIDTH'(magnitude(64'(s_axis_divisor_tdata), b_sign));
                    quo_d    = WIDTH'(magnitude(64'(s_axis_dividend_tdata), a_sign));
                    rem_d    = '0;
                end
            end
            DIV_CALC: begin
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], trial_ok};
                    rem_d = trial_ok ? WIDTH'(shifted - {1'b0, bmag_q}) : shifted[WIDTH-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = DIV_FIX;
                    end
                end
            end
            DIV_FIX: begin
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_DONE;
                    valid_d = 1'b1;
                    dout_d  = b_zero_q ? {{WIDTH{1'b1}}, a_raw_q} : {q_fix, r_fix};
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            bmag_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            a_raw_q  <= a_raw_d;
            bmag_q   <= bmag_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_mdu_div_iter.sv
// Directed and randomised bench for mdu_div_iter: latency, handshake, flush, reset.
module tb_mdu_div_iter;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic           s_axis_signed;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           flush;
    logic           busy;
    logic           m_valid;
    logic [2*W-1:0] m_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          sgn;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [63:0]   exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    mdu_div_iter #(.WIDTH(W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_axis_tvalid         (s_axis_tvalid),
        .s_axis_tready         (s_axis_tready),
        .s_axis_signed         (s_axis_signed),
        .s_axis_dividend_tdata (dividend),
        .s_axis_divisor_tdata  (divisor),
        .flush                 (flush),
        .busy                  (busy),
        .m_axis_dout_tvalid    (m_valid),
        .m_axis_dout_tdata     (m_data)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        return {32'(sa / sb), 32'(sa % sb)};
    endfunction

    // Called at a negedge; returns just after the accepting edge with operands scrambled.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        chk("ready_before_accept", 64'(s_axis_tready), 64'd1);
        chk("idle_before_accept", 64'(busy), 64'd0);
        s_axis_signed = sgn;
        dividend      = a;
        divisor       = b;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_signed = ~sgn;
        dividend      = $urandom;
        divisor       = $urandom;
    endtask

    // Returns at the negedge of the valid cycle; lat counts cycles after the accept cycle.
    task automatic wait_result(output logic [63:0] res, output int lat);
        logic hs_bad;
        hs_bad = 1'b0;
        lat    = -1;
        res    = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_axis_tready || !busy) hs_bad = 1'b1;
            if (m_valid) begin
                lat = k;
                res = m_data;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(34));
        chk("ready_low_busy_high", 64'(hs_bad), 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        pulse;
        int          lat;

        vecs[0]  = '{1'b0, 32'd7,          32'd2,          64'h00000003_00000001};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFD_FFFFFFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'hFFFFFFFD_00000001};
        vecs[3]  = '{1'b1, 32'h1234_5678,  32'd0,          64'hFFFFFFFF_12345678};
        vecs[4]  = '{1'b0, 32'h1234_5678,  32'd0,          64'hFFFFFFFF_12345678};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'hFFFFFFFF_00000000};
        vecs[7]  = '{1'b0, 32'd100,        32'd7,          64'h0000000E_00000002};
        vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'h00000003_FFFFFFFF};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000001_00000000};
        vecs[10] = '{1'b1, 32'h8000_0000,  32'd0,          64'hFFFFFFFF_80000000};
        vecs[11] = '{1'b0, 32'd5,          32'd10,         64'h00000000_00000005};

        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_signed = 1'b0;
        dividend      = '0;
        divisor       = '0;
        flush         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(m_valid), 64'd0);
        chk("reset_data", m_data, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ready", 64'(s_axis_tready), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_result(res, lat);
            chk($sformatf("vector_%0d", i), res, vecs[i].exp);
        end

        // Flush while idle must block the accept.
        @(negedge clk);
        flush         = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_signed = 1'b0;
        dividend      = 32'd9;
        divisor       = 32'd3;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        flush         = 1'b0;
        @(negedge clk);
        chk("flush_idle_blocks", 64'(busy), 64'd0);

        // Flush mid-CALC at T0+10, then a fresh accept at T0+11.
        prev  = m_data;
        pulse = 1'b0;
        start_op(1'b0, 32'd1000, 32'd3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (m_valid) pulse = 1'b1;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        chk("flush_no_pulse", 64'(pulse | m_valid), 64'd0);
        chk("flush_data_held", m_data, prev);
        start_op(1'b0, 32'd100, 32'd7);
        wait_result(res, lat);
        chk("after_flush", res, 64'h0000000E_00000002);

        // Reset at T0+20 kills the operation and clears the result.
        @(negedge clk);
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("midop_reset_data", m_data, 64'd0);
        chk("midop_reset_busy", 64'(busy), 64'd0);
        pulse = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_valid) pulse = 1'b1;
        end
        chk("midop_reset_no_pulse", 64'(pulse), 64'd0);
        chk("midop_reset_data_after", m_data, 64'd0);

        // Back-to-back: second accept lands at T0+35.
        @(negedge clk);
        start_op(1'b0, 32'd7, 32'd2);
        wait_result(res, lat);
        chk("b2b_first", res, 64'h00000003_00000001);
        @(negedge clk);
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_result(res, lat);
        chk("b2b_second", res, 64'hFFFFFFFD_00000001);

        for (int n = 0; n < 1000; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            @(negedge clk);
            start_op(rs, ra, rb);
            wait_result(res, lat);
            chk($sformatf("sweep_%0d s=%0d a=%h b=%h", n, rs, ra, rb), res, ref_div(rs, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
